sort_arbiter: RTL and testbench
===============================

SORT_ARBITER -- requirements
Module: sort_arbiter

Interface
REQ-001 Parameter N, default 8, number of elements per frame.
REQ-002 Parameter WIDTH, default 8, bits per element.
REQ-003 Parameter TIMEOUT, default 1024, max cycles to wait for sorter done.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid_i  input  2  frame request valid, bit k = requester k.
REQ-007 req_ready_o  output  2  frame accept, bit k = requester k.
REQ-008 req0_data_i  input  N*WIDTH  requester 0 frame, element i at bits [i*WIDTH +: WIDTH].
REQ-009 req1_data_i  input  N*WIDTH  requester 1 frame, same packing.
REQ-010 rsp_valid_o  output  2  result valid, bit k = requester k.
REQ-011 rsp_ready_i  input  2  result accept, bit k = requester k.
REQ-012 rsp_data_o  output  N*WIDTH  sorted frame, shared by both requesters.
REQ-013 rsp_err_o  output  1  result is a timeout error, qualified by rsp_valid_o.
REQ-014 sort_start_o  output  1  one-cycle start pulse to the shared sorter.
REQ-015 sort_data_o  output  N*WIDTH  frame driven to sorter, stable from start until done.
REQ-016 sort_data_i  input  N*WIDTH  sorter result, valid when sort_done_i=1.
REQ-017 sort_done_i  input  1  sorter completion, sampled only in WAIT.
REQ-018 busy_o  output  1  high in every state except IDLE.
REQ-019 owner_o  output  1  index of requester currently owning the sorter.

Function
REQ-020 FSM states: IDLE, START, WAIT, RESP; exactly one active.
REQ-021 IDLE: no req_valid_i bit set -> stay IDLE, req_ready_o=00.
REQ-022 IDLE, exactly one req_valid_i bit set -> that requester wins.
REQ-023 IDLE, both set -> requester equal to priority pointer prio wins.
REQ-024 req_ready_o is combinational: winner bit high in IDLE only, loser bit 0; transfer = valid & ready.
REQ-025 On transfer: winner frame latched into sort_data_o register, owner_o <= winner, state -> START.
REQ-026 START: sort_start_o=1 for exactly one cycle, wait counter cleared, state -> WAIT; sort_done_i ignored in START.
REQ-027 WAIT: counter increments each cycle; sort_done_i=1 -> rsp_data_o <= sort_data_i, rsp_err_o <= 0, state -> RESP.
REQ-028 WAIT: counter reaches TIMEOUT-1 without done -> rsp_data_o <= 0, rsp_err_o <= 1, state -> RESP; done in that same cycle wins over timeout.
REQ-029 RESP: rsp_valid_o[owner_o]=1, other bit 0; rsp_data_o/rsp_err_o held stable until accepted.
REQ-030 RESP and rsp_ready_i[owner_o]=1 -> prio <= ~owner_o, state -> IDLE; rsp_ready_i of non-owner ignored.
REQ-031 sort_data_o unchanged outside transfer cycle; sort_done_i in IDLE/START/RESP has no effect.
REQ-032 Minimum latency: transfer at cycle T, sort_start_o at T+1, rsp_valid_o earliest at T+3 (done at T+2).
REQ-033 New request accepted no earlier than the cycle after response acceptance (no overlap).
REQ-034 Counter width ceil(log2(TIMEOUT))+1 bits, no wrap before TIMEOUT.

Reset
REQ-035 rst=1 asynchronously forces: state IDLE, prio 0, owner_o 0, counter 0, sort_start_o 0, rsp_valid_o 00, rsp_err_o 0, rsp_data_o 0, sort_data_o 0, busy_o 0.
REQ-036 Reset in any state (including WAIT, RESP) aborts the frame; no response issued; late sort_done_i after reset ignored.

Verification
REQ-037 Req0 only, frame {5,3,7,1,0,2,6,4}, sorter done 10 cycles after start -> one start pulse, rsp_valid_o=01, rsp_data_o={0..7}, rsp_err_o=0.
REQ-038 Both valid after reset -> requester 0 granted first; after its response, both still valid -> requester 1 granted; alternation continues.
REQ-039 Sorter never asserts done, TIMEOUT=16 -> rsp_valid_o asserted 16 cycles after WAIT entry, rsp_err_o=1, rsp_data_o=0.
REQ-040 rsp_ready_i held 0 for 20 cycles in RESP -> rsp_valid_o and rsp_data_o stable, req_ready_o=00, no new start.
REQ-041 rst pulsed during WAIT -> all outputs reset values, later sort_done_i produces no rsp_valid_o.
REQ-042 sort_done_i asserted in IDLE and START cycle -> ignored; response only on done in WAIT.

Source files
------------

// File: rtl/sort_arbiter.sv
// sort_arbiter: two-requester front end for a single shared sorter.
// Grants one frame at a time (fixed preference when only one requests,
// round-robin pointer when both do), launches the sorter, waits for done
// or a timeout, then returns the result to the owning requester.
module sort_arbiter #(
  parameter int N       = 8,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [N*WIDTH-1:0]   req0_data_i,
  input  logic [N*WIDTH-1:0]   req1_data_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [N*WIDTH-1:0]   rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 sort_start_o,
  output logic [N*WIDTH-1:0]   sort_data_o,
  input  logic [N*WIDTH-1:0]   sort_data_i,
  input  logic                 sort_done_i,
  output logic                 busy_o,
  output logic                 owner_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic          prio;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          winner;
  logic          transfer;

  // Arbitration: single requester wins outright, a tie goes to the pointer.
  always_comb begin
    any_req     = |req_valid_i;
    winner      = (req_valid_i == 2'b11) ? prio : req_valid_i[1];
    req_ready_o = 2'b00;
    if (state == IDLE && any_req) begin
      req_ready_o = winner ? 2'b10 : 2'b01;
    end
    transfer    = |(req_valid_i & req_ready_o);
  end

  // State-decoded outputs.
  always_comb begin
    sort_start_o = (state == START);
    busy_o       = (state != IDLE);
    owner_o      = owner;
    rsp_valid_o  = 2'b00;
    if (state == RESP) begin
      rsp_valid_o = owner ? 2'b10 : 2'b01;
    end
  end

  // Frame sequencing: accept, launch, wait for done/timeout, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      rsp_err_o   <= 1'b0;
      rsp_data_o  <= '0;
      sort_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            sort_data_o <= winner ? req1_data_i : req0_data_i;
            owner       <= winner;
            state       <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done is checked first so a completion on the last allowed cycle
          // still returns data rather than an error.
          if (sort_done_i) begin
            rsp_data_o <= sort_data_i;
            rsp_err_o  <= 1'b0;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (rsp_ready_i[owner]) begin
            prio  <= ~owner;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_arbiter.sv
// Self-checking bench for sort_arbiter: a vector table of frame transactions
// plus hand-written reset-abort and stray-done sequences, with a response
// scoreboard fed at grant time and drained when rsp_valid_o appears.
module tb_sort_arbiter;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int DW = N * W;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid_i = '0;
  logic [1:0]    req_ready_o;
  logic [DW-1:0] req0_data_i = '0;
  logic [DW-1:0] req1_data_i = '0;
  logic [1:0]    rsp_valid_o;
  logic [1:0]    rsp_ready_i = '0;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic          sort_start_o;
  logic [DW-1:0] sort_data_o;
  logic [DW-1:0] sort_data_i = '0;
  logic          sort_done_i = 1'b0;
  logic          busy_o;
  logic          owner_o;

  sort_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_data_i(req0_data_i), .req1_data_i(req1_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .sort_start_o(sort_start_o), .sort_data_o(sort_data_o),
    .sort_data_i(sort_data_i), .sort_done_i(sort_done_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    valid;
    logic [DW-1:0] f0;
    logic [DW-1:0] f1;
    int            delay;   // WAIT cycles before done; -1 = never
    int            hold;    // cycles rsp_ready_i[owner] held low in RESP
    logic          owner;
    logic          err;
  } vec_t;

  typedef struct {
    logic [1:0]    valid;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [DW-1:0] FA = 64'h0406020001070305; // {5,3,7,1,0,2,6,4}
  localparam logic [DW-1:0] FB = 64'h11f0803c00ff7e22;
  localparam logic [DW-1:0] FC = 64'h090901aa55001002;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference sorter: ascending, element 0 smallest.
  function automatic logic [DW-1:0] sort_frame(input logic [DW-1:0] f);
    logic [W-1:0]  a [N];
    logic [W-1:0]  t;
    logic [DW-1:0] r;
    for (int i = 0; i < N; i++) a[i] = f[i*W +: W];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  task automatic check_resp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_unexpected"}, {62'd0, rsp_valid_o}, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_valid"}, {62'd0, rsp_valid_o}, {62'd0, e.valid});
      chk({name, "_data"}, rsp_data_o, e.data);
      chk({name, "_err"}, {63'd0, rsp_err_o}, {63'd0, e.err});
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    logic [DW-1:0] fr;
    logic [DW-1:0] srt;
    logic [1:0]    own_bit;
    exp_t          e;
    int            cyc;
    string         nm;
    nm      = $sformatf("v%0d", idx);
    fr      = v.owner ? v.f1 : v.f0;
    srt     = sort_frame(fr);
    own_bit = v.owner ? 2'b10 : 2'b01;
    req_valid_i = v.valid;
    req0_data_i = v.f0;
    req1_data_i = v.f1;
    #1;
    chk({nm, "_req_ready"}, {62'd0, req_ready_o}, {62'd0, own_bit});
    e.valid = own_bit;
    e.data  = v.err ? '0 : srt;
    e.err   = v.err;
    sb.push_back(e);
    step();
    chk({nm, "_start"}, {63'd0, sort_start_o}, 64'd1);
    chk({nm, "_sort_data"}, sort_data_o, fr);
    chk({nm, "_owner"}, {63'd0, owner_o}, {63'd0, v.owner});
    chk({nm, "_ready_busy"}, {62'd0, req_ready_o}, 64'd0);
    step();
    chk({nm, "_start_once"}, {63'd0, sort_start_o}, 64'd0);
    cyc = 0;
    sort_data_i = srt;
    while (rsp_valid_o == 2'b00 && cyc < TO + 8) begin
      sort_done_i = (cyc == v.delay);
      step();
      cyc++;
    end
    sort_done_i = 1'b0;
    chk({nm, "_latency"}, 64'(cyc), 64'(v.delay >= 0 ? v.delay + 1 : TO));
    check_resp(nm);
    // Stall the response; non-owner ready and stray done must be ignored.
    rsp_ready_i = ~own_bit;
    sort_done_i = 1'b1;
    sort_data_i = ~srt;
    for (int h = 0; h < v.hold; h++) begin
      step();
      chk({nm, "_hold_ctl"}, {59'd0, rsp_valid_o, rsp_err_o, req_ready_o, sort_start_o},
          {59'd0, own_bit, v.err, 2'b00, 1'b0});
      chk({nm, "_hold_data"}, rsp_data_o, e.data);
    end
    sort_done_i = 1'b0;
    rsp_ready_i = own_bit;
    #1;
    chk({nm, "_no_overlap"}, {62'd0, req_ready_o}, 64'd0);
    step();
    rsp_ready_i = 2'b00;
    chk({nm, "_idle"}, {61'd0, busy_o, rsp_valid_o}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {57'd0, busy_o, rsp_valid_o, rsp_err_o, sort_start_o, owner_o, req_ready_o},
        64'd0);
    chk({nm, "_rsp_data"}, rsp_data_o, 64'd0);
    chk({nm, "_sort_data"}, sort_data_o, 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{valid: 2'b01, f0: FA, f1: FB, delay: 9,  hold: 0,  owner: 1'b0, err: 1'b0};
    vecs[1] = '{valid: 2'b11, f0: FB, f1: FC, delay: 0,  hold: 0,  owner: 1'b1, err: 1'b0};
    vecs[2] = '{valid: 2'b11, f0: FC, f1: FA, delay: 3,  hold: 20, owner: 1'b0, err: 1'b0};
    vecs[3] = '{valid: 2'b11, f0: FA, f1: FB, delay: -1, hold: 2,  owner: 1'b1, err: 1'b1};
    vecs[4] = '{valid: 2'b10, f0: FB, f1: FC, delay: 15, hold: 0,  owner: 1'b1, err: 1'b0};
    vecs[5] = '{valid: 2'b11, f0: FB, f1: FA, delay: 1,  hold: 1,  owner: 1'b0, err: 1'b0};
    vecs[6] = '{valid: 2'b01, f0: FC, f1: FB, delay: 2,  hold: 0,  owner: 1'b0, err: 1'b0};

    // Asynchronous reset with no clock edge required.
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);
    req_valid_i = 2'b00;
    step();

    // Reset in WAIT aborts the frame; late done afterwards is ignored.
    req_valid_i = 2'b10;
    req1_data_i = FB;
    step();
    step();
    step();
    chk("abort_in_wait", {62'd0, busy_o, sort_start_o}, 64'd2);
    req_valid_i = 2'b00;
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    sort_data_i = sort_frame(FB);
    sort_done_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("late_done", {61'd0, busy_o, rsp_valid_o}, 64'd0);
    end

    // Done in IDLE and START is ignored; pointer back at 0 after reset.
    req_valid_i = 2'b11;
    req0_data_i = FA;
    req1_data_i = FC;
    sort_data_i = 64'hdeadbeefcafef00d;
    #1;
    chk("post_reset_prio", {62'd0, req_ready_o}, 64'd1);
    sb.push_back('{valid: 2'b01, data: sort_frame(FA), err: 1'b0});
    step();
    req_valid_i = 2'b00;
    chk("stray_start", {63'd0, sort_start_o}, 64'd1);
    step();
    chk("done_in_start", {61'd0, busy_o, rsp_valid_o}, 64'd4);
    sort_done_i = 1'b0;
    sort_data_i = sort_frame(FA);
    step();
    chk("wait_no_done", {62'd0, rsp_valid_o}, 64'd0);
    sort_done_i = 1'b1;
    step();
    sort_done_i = 1'b0;
    check_resp("stray");
    rsp_ready_i = 2'b01;
    step();
    rsp_ready_i = 2'b00;
    chk("stray_idle", {61'd0, busy_o, rsp_valid_o}, 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
